// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Holds the FSM encoding, the default abort timeout and the memory command payload.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // True while a memory access is outstanding.
    function automatic logic is_busy(input arb_state_e s);
        return (s == IFETCH) || (s == DACCESS);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory command port and pipeline status.
// The arbiter takes the slave view; the requesting pipeline plus memory take the master view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_gnt, if_rdata, dm_done, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall, bus_err
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_gnt, if_rdata, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall, bus_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles an access has waited on memory; expired flags the last permitted wait.
module mem_wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned          CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = (count_q == LAST);

    // Holds at the limit so a late enable cannot wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the MEM-stage data port.
// Data accesses win ties; a stuck memory is aborted after TIMEOUT waits with bus_err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_done_q, dm_done_d;
    logic              bus_err_q, bus_err_d;

    logic              busy;
    logic              expired;
    logic              finish;

    assign busy   = is_busy(state_q);
    assign finish = bus.mem_ready || expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !bus.mem_ready),
        .expired (expired)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_gnt_d   = 1'b0;
        dm_done_d  = 1'b0;
        bus_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.dm_read || bus.dm_write) begin
                    state_d = DACCESS;
                    cmd_d   = '{en: 1'b1, we: bus.dm_write, addr: bus.dm_addr, wdata: bus.dm_wdata};
                end else if (bus.if_req) begin
                    state_d = IFETCH;
                    cmd_d   = '{en: 1'b1, we: 1'b0, addr: bus.if_addr, wdata: cmd_q.wdata};
                end
            end
            IFETCH: begin
                if (finish) begin
                    state_d    = DONE;
                    cmd_d.en   = 1'b0;
                    if_gnt_d   = 1'b1;
                    bus_err_d  = !bus.mem_ready;
                    if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                end
            end
            DACCESS: begin
                if (finish) begin
                    state_d   = DONE;
                    cmd_d.en  = 1'b0;
                    cmd_d.we  = 1'b0;
                    dm_done_d = 1'b1;
                    bus_err_d = !bus.mem_ready;
                    // Stores never disturb the last load value.
                    if (!cmd_q.we) begin
                        dm_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_gnt_q   <= 1'b0;
            dm_done_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_gnt_q   <= if_gnt_d;
            dm_done_q  <= dm_done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.mem_en    = cmd_q.en;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.bus_err   = bus_err_q;

    // Pipeline hold is the only combinational output.
    assign bus.stall = ((bus.dm_read | bus.dm_write) & ~dm_done_q) | (bus.if_req & ~if_gnt_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected commands and completions,
// a negedge monitor pops and compares whenever the arbiter issues a command or a pulse.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic clock = 1'b0;
    logic reset;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    resp_t resp_q[$];
    cmd_t  cmd_q[$];
    int    mem_waits = 0;
    bit    mem_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C01_0004;
            32'h0000_0044: return 32'h0022_1820;
            32'h0000_0048: return 32'hAC02_0008;
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0104: return 32'h0BAD_F00D;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    // Memory model: ready after mem_waits cycles of mem_en, never if stuck.
    initial begin
        int wcnt;
        wcnt          = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_en) begin
                bus.mem_ready = !mem_stuck && (wcnt >= mem_waits);
                bus.mem_rdata = rom(bus.mem_addr);
                wcnt++;
            end else begin
                bus.mem_ready = 1'b0;
                wcnt          = 0;
            end
        end
    end

    // Monitor: compares memory commands and completion pulses against the queues.
    initial begin
        bit    en_prev;
        cmd_t  cur;
        resp_t r;
        en_prev = 1'b0;
        cur     = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        forever begin
            @(negedge clock);
            if (bus.mem_en && !en_prev) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: mem_en high at addr %h, none required", bus.mem_addr);
                end else begin
                    cur = cmd_q.pop_front();
                    check("cmd_we", bus.mem_we, cur.we);
                    check("cmd_addr", bus.mem_addr, cur.addr);
                    if (cur.we) check("cmd_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (bus.mem_en) begin
                check("cmd_held_we", bus.mem_we, cur.we);
                check("cmd_held_addr", bus.mem_addr, cur.addr);
                if (cur.we) check("cmd_held_wdata", bus.mem_wdata, cur.wdata);
            end
            en_prev = bus.mem_en;

            if (bus.if_gnt && bus.dm_done) begin
                checks++; errors++;
                $display("FAIL pulse_overlap: if_gnt=1 dm_done=1, required at most one");
            end
            if (bus.bus_err && !(bus.if_gnt || bus.dm_done)) begin
                checks++; errors++;
                $display("FAIL lone_bus_err: bus_err=1 without completion, required paired");
            end
            if (bus.if_gnt || bus.dm_done) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: if_gnt=%b dm_done=%b, none required", bus.if_gnt, bus.dm_done);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_if_gnt", bus.if_gnt, !r.is_data);
                    check("resp_dm_done", bus.dm_done, r.is_data);
                    check("resp_bus_err", bus.bus_err, r.err);
                    if (r.is_data) check("resp_dm_rdata", bus.dm_rdata, r.rdata);
                    else           check("resp_if_rdata", bus.if_rdata, r.rdata);
                end
            end
        end
    end

    // One request; called on a negedge with the arbiter idle, returns one cycle after completion.
    task automatic do_req(input string name, input bit is_data, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit stuck,
                          input logic [31:0] exp_rdata, input bit exp_err,
                          input int exp_lat, input int drop_after);
        int lat;
        bit seen;
        bit held;
        cmd_q.push_back('{we: is_data && wr, addr: addr, wdata: wdata});
        resp_q.push_back('{is_data: is_data, rdata: exp_rdata, err: exp_err});
        mem_waits = waits;
        mem_stuck = stuck;
        if (is_data) begin
            bus.dm_read  = rd;
            bus.dm_write = wr;
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        held = 1'b1;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 100) begin
            @(negedge clock);
            lat++;
            if (is_data ? bus.dm_done : bus.if_gnt) begin
                seen = 1'b1;
            end else begin
                if (held) check({name, "_stall"}, bus.stall, 1'b1);
                if (lat == drop_after) begin
                    bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.if_req = 1'b0;
                    held = 1'b0;
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no completion after %0d cycles, required at %0d", name, lat, exp_lat);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
        end
        bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.if_req = 1'b0;
        @(negedge clock);
        check({name, "_idle_stall"}, bus.stall, 1'b0);
    endtask

    initial begin
        int lat;
        bit seen;
        reset        = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        repeat (3) @(negedge clock);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_if_gnt", bus.if_gnt, 1'b0);
        check("rst_dm_done", bus.dm_done, 1'b0);
        check("rst_bus_err", bus.bus_err, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        do_req("fetch_wait2", 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h8C01_0004, 1'b0, 4, 0);
        do_req("fetch_min",   1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h0022_1820, 1'b0, 2, 0);

        // Fetch and load together: load first, fetch on the following arbitration.
        cmd_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        cmd_q.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
        resp_q.push_back('{is_data: 1'b1, rdata: 32'hDEAD_BEEF, err: 1'b0});
        resp_q.push_back('{is_data: 1'b0, rdata: 32'hAC02_0008, err: 1'b0});
        mem_waits    = 0;
        mem_stuck    = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h48;
        bus.dm_read  = 1'b1;
        bus.dm_addr  = 32'h100;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 100) begin
            @(negedge clock);
            lat++;
            check("both_stall_d", bus.stall, 1'b1);
            if (bus.dm_done) seen = 1'b1;
        end
        check("both_data_seen", seen, 1'b1);
        check("both_data_latency", lat, 2);
        bus.dm_read = 1'b0;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.if_gnt) seen = 1'b1;
            else check("both_stall_f", bus.stall, 1'b1);
        end
        check("both_fetch_seen", seen, 1'b1);
        check("both_fetch_latency", lat, 3);
        bus.if_req = 1'b0;
        @(negedge clock);

        do_req("store",      1'b1, 1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 5, 0);
        do_req("rd_and_wr",  1'b1, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 0);
        do_req("load",       1'b1, 1'b1, 1'b0, 32'h104, 32'h0,         1, 1'b0, 32'h0BAD_F00D, 1'b0, 3, 0);
        do_req("timeout",    1'b1, 1'b1, 1'b0, 32'h100, 32'h0,         0, 1'b1, 32'h0,         1'b1, TIMEOUT + 1, 0);
        do_req("after_to",   1'b0, 1'b0, 1'b0, 32'h40,  32'h0,         0, 1'b0, 32'h8C01_0004, 1'b0, 2, 0);

        // Reset in the middle of a stuck load: access dropped, no completion.
        cmd_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        mem_stuck   = 1'b1;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h100;
        repeat (4) @(negedge clock);
        check("mid_mem_en", bus.mem_en, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_mem_en", bus.mem_en, 1'b0);
        check("mid_rst_dm_done", bus.dm_done, 1'b0);
        check("mid_rst_if_rdata", bus.if_rdata, 32'h0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        reset       = 1'b0;
        bus.dm_read = 1'b0;
        mem_stuck   = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_mem_en", bus.mem_en, 1'b0);

        do_req("post_rst",   1'b0, 1'b0, 1'b0, 32'h44,  32'h0, 0, 1'b0, 32'h0022_1820, 1'b0, 2, 0);
        do_req("dropped",    1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 1'b0, 5, 1);

        repeat (4) @(negedge clock);
        check("resp_q_empty", resp_q.size(), 0);
        check("cmd_q_empty", cmd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
